// File: rtl/full_adder.sv
// Registered N-bit ripple-carry adder with carry-out and signed-overflow flags.
// One result per cycle, one cycle of latency, outputs hold while no input is valid.
module full_adder #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid
);

    logic [N:0]   carry;
    logic [N-1:0] sum_d;
    logic         cout_d;
    logic         ovf_d;

    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         out_valid_q;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            assign sum_d[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
        end
    endgenerate

    // carry[N-1] is cin when N=1, so this also covers the single-bit case.
    assign cout_d = carry[N];
    assign ovf_d  = carry[N] ^ carry[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at N=16 (directed), N=4 (exhaustive), N=1 and N=32 (random).
module tb_full_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [15:0] a16, b16, sum16;
    logic        cin16, iv16, cout16, ovf16, ov16;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, iv4, cout4, ovf4, ov4;
    logic [0:0]  a1, b1, sum1;
    logic        cin1, iv1, cout1, ovf1, ov1;
    logic [31:0] a32, b32, sum32;
    logic        cin32, iv32, cout32, ovf32, ov32;

    exp_t q16[$];
    exp_t q4[$];
    exp_t q1[$];
    exp_t q32[$];

    int total = 0;
    int bad   = 0;

    full_adder #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .in_valid(iv16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .out_valid(ov16)
    );
    full_adder #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .out_valid(ov4)
    );
    full_adder #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
    );
    full_adder #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32), .in_valid(iv32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .out_valid(ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide integer add, overflow from operand and result sign bits.
    function automatic exp_t model(input int n, input logic [63:0] a, input logic [63:0] b, input logic cin);
        exp_t        e;
        logic [64:0] full;
        logic [63:0] mask;
        full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        mask   = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        e.sum  = full[63:0] & mask;
        e.cout = full[n];
        e.ovf  = (a[n-1] == b[n-1]) && (full[n-1] != a[n-1]);
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1;
        iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        e.sum = 64'd0; e.cout = 1'b0; e.ovf = 1'b0;
        total++;
        if ({sum16, cout16, ovf16, ov16} !== {e.sum[15:0], e.cout, e.ovf, 1'b0}) begin
            bad++;
            $display("FAIL reset16: got sum=%h cout=%b ovf=%b ov=%b want all zero", sum16, cout16, ovf16, ov16);
        end
        total++;
        if ({sum4, cout4, ovf4, ov4, sum1, cout1, ovf1, ov1, sum32, cout32, ovf32, ov32} !== '0) begin
            bad++;
            $display("FAIL reset_others: got ov4=%b ov1=%b ov32=%b sum32=%h want all zero", ov4, ov1, ov32, sum32);
        end
        $display("reset: outputs checked while rst_n low");
        iv16 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va[7] = '{16'd1, 16'd6, 16'd11, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb[7] = '{16'd2, 16'd8, 16'd13, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
        logic        vc[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        // Constants from the directed/wrap/overflow tables, pushed alongside the model check.
        logic [15:0] ws[7] = '{16'd3, 16'd15, 16'd25, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
        logic        wc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        wo[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            a16 = va[i]; b16 = vb[i]; cin16 = vc[i]; iv16 = 1'b1;
            e.sum = {48'd0, ws[i]}; e.cout = wc[i]; e.ovf = wo[i];
            q16.push_back(e);
            @(negedge clk);
            iv16 = 1'b0;
            e = q16.pop_front();
            total++;
            if (ov16 !== 1'b1 || sum16 !== e.sum[15:0] || cout16 !== e.cout || ovf16 !== e.ovf) begin
                bad++;
                $display("FAIL directed[%0d]: got ov=%b sum=%h cout=%b ovf=%b want ov=1 sum=%h cout=%b ovf=%b",
                         i, ov16, sum16, cout16, ovf16, e.sum[15:0], e.cout, e.ovf);
            end
            $display("directed[%0d]: a=%h b=%h cin=%b sum=%h cout=%b ovf=%b", i, va[i], vb[i], vc[i], sum16, cout16, ovf16);
            @(negedge clk);
            total++;
            if (ov16 !== 1'b0) begin
                bad++;
                $display("FAIL directed_idle[%0d]: got out_valid=%b want 0", i, ov16);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i <= 20; i++) begin
            if (q16.size() > 0) begin
                e = q16.pop_front();
                total++;
                if (ov16 !== 1'b1 || sum16 !== e.sum[15:0] || cout16 !== e.cout || ovf16 !== e.ovf) begin
                    bad++;
                    $display("FAIL b2b[%0d]: got ov=%b sum=%h cout=%b ovf=%b want ov=1 sum=%h cout=%b ovf=%b",
                             i, ov16, sum16, cout16, ovf16, e.sum[15:0], e.cout, e.ovf);
                end
                $display("b2b[%0d]: sum=%h cout=%b ovf=%b", i, sum16, cout16, ovf16);
            end
            if (i < 20) begin
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'b1;
                q16.push_back(model(16, {48'd0, a16}, {48'd0, b16}, cin16));
            end else begin
                iv16 = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        a16 = 16'h0F0F; b16 = 16'h00F2; cin16 = 1'b1; iv16 = 1'b1;
        e.sum = 64'h1002; e.cout = 1'b0; e.ovf = 1'b0;
        q16.push_back(e);
        @(negedge clk);
        e = q16.pop_front();
        total++;
        if (ov16 !== 1'b1 || sum16 !== e.sum[15:0] || cout16 !== e.cout) begin
            bad++;
            $display("FAIL hold_load: got ov=%b sum=%h cout=%b want ov=1 sum=%h cout=%b", ov16, sum16, cout16, e.sum[15:0], e.cout);
        end
        iv16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        @(negedge clk);
        a16 = 16'h8000; b16 = 16'h8000;
        #2;
        total++;
        if (ov16 !== 1'b0 || sum16 !== e.sum[15:0] || cout16 !== e.cout || ovf16 !== e.ovf) begin
            bad++;
            $display("FAIL hold: got ov=%b sum=%h cout=%b ovf=%b want ov=0 sum=%h cout=%b ovf=%b",
                     ov16, sum16, cout16, ovf16, e.sum[15:0], e.cout, e.ovf);
        end
        $display("hold: sum=%h cout=%b out_valid=%b after in_valid dropped", sum16, cout16, ov16);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        a16 = 16'hF234; b16 = 16'h4321; cin16 = 1'b0; iv16 = 1'b1;
        e = model(16, {48'd0, a16}, {48'd0, b16}, cin16);
        @(negedge clk);
        total++;
        if (ov16 !== 1'b1 || sum16 !== e.sum[15:0] || cout16 !== e.cout) begin
            bad++;
            $display("FAIL areset_pre: got ov=%b sum=%h cout=%b want ov=1 sum=%h cout=%b", ov16, sum16, cout16, e.sum[15:0], e.cout);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sum16, cout16, ovf16, ov16} !== 19'd0) begin
            bad++;
            $display("FAIL areset_immediate: got sum=%h cout=%b ovf=%b ov=%b want all zero", sum16, cout16, ovf16, ov16);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({sum16, cout16, ovf16, ov16} !== 19'd0) begin
            bad++;
            $display("FAIL areset_held: got sum=%h cout=%b ovf=%b ov=%b want all zero", sum16, cout16, ovf16, ov16);
        end
        iv16 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({sum16, cout16, ovf16, ov16} !== 19'd0) begin
            bad++;
            $display("FAIL areset_idle: got sum=%h cout=%b ovf=%b ov=%b want all zero", sum16, cout16, ovf16, ov16);
        end
        iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        total++;
        if (ov16 !== 1'b1 || sum16 !== e.sum[15:0] || cout16 !== e.cout) begin
            bad++;
            $display("FAIL areset_resume: got ov=%b sum=%h cout=%b want ov=1 sum=%h cout=%b", ov16, sum16, cout16, e.sum[15:0], e.cout);
        end
        $display("async reset: cleared mid-cycle, resumed with sum=%h", sum16);
        @(negedge clk);
    endtask

    task automatic test_exhaustive_n4();
        exp_t e;
        int   errs = 0;
        for (int i = 0; i <= 512; i++) begin
            if (q4.size() > 0) begin
                e = q4.pop_front();
                total++;
                if (ov4 !== 1'b1 || sum4 !== e.sum[3:0] || cout4 !== e.cout || ovf4 !== e.ovf) begin
                    bad++; errs++;
                    $display("FAIL n4[%0d]: got ov=%b sum=%h cout=%b ovf=%b want ov=1 sum=%h cout=%b ovf=%b",
                             i - 1, ov4, sum4, cout4, ovf4, e.sum[3:0], e.cout, e.ovf);
                end
            end
            if (i < 512) begin
                {a4, b4, cin4} = 9'(i);
                iv4 = 1'b1;
                q4.push_back(model(4, {60'd0, a4}, {60'd0, b4}, cin4));
            end else begin
                iv4 = 1'b0;
            end
            @(negedge clk);
        end
        $display("exhaustive N=4: 512 vectors, %0d errors", errs);
    endtask

    task automatic test_random();
        exp_t e;
        int   errs = 0;
        for (int i = 0; i <= 10000; i++) begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                total++;
                if (ov1 !== 1'b1 || sum1 !== e.sum[0:0] || cout1 !== e.cout || ovf1 !== e.ovf) begin
                    bad++; errs++;
                    $display("FAIL n1[%0d]: got ov=%b sum=%b cout=%b ovf=%b want ov=1 sum=%b cout=%b ovf=%b",
                             i - 1, ov1, sum1, cout1, ovf1, e.sum[0], e.cout, e.ovf);
                end
                e = q32.pop_front();
                total++;
                if (ov32 !== 1'b1 || sum32 !== e.sum[31:0] || cout32 !== e.cout || ovf32 !== e.ovf) begin
                    bad++; errs++;
                    $display("FAIL n32[%0d]: got ov=%b sum=%h cout=%b ovf=%b want ov=1 sum=%h cout=%b ovf=%b",
                             i - 1, ov32, sum32, cout32, ovf32, e.sum[31:0], e.cout, e.ovf);
                end
            end
            if (i < 10000) begin
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); iv1 = 1'b1;
                a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); iv32 = 1'b1;
                q1.push_back(model(1, {63'd0, a1}, {63'd0, b1}, cin1));
                q32.push_back(model(32, {32'd0, a32}, {32'd0, b32}, cin32));
            end else begin
                iv1 = 1'b0; iv32 = 1'b0;
            end
            @(negedge clk);
        end
        $display("random N=1 and N=32: 10000 vectors each, %0d errors", errs);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_exhaustive_n4();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the operand and sum width in bits; legal range 1..64.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk: input, 1 bit, rising-edge clock.
- rst_n: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the following data ports.
- a: input, N bits, unsigned addend.
- b: input, N bits, unsigned addend.
- cin: input, 1 bit, carry-in.
- in_valid: input, 1 bit, qualifies a, b and cin on this clock edge.
- sum: output, N bits, registered sum (a+b+cin) mod 2^N.
- cout: output, 1 bit, registered carry-out, bit N of a+b+cin.
- ovf: output, 1 bit, registered two's-complement overflow flag.
- out_valid: output, 1 bit, registered; high when sum, cout and ovf hold a fresh result.
REQ-004 Port order SHALL be: clk, rst_n, a, b, cin, in_valid, sum, cout, ovf, out_valid.

Function
REQ-005 The adder SHALL be a ripple-carry chain of N one-bit full-adder cells built with a generate loop.
- Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
- c_0 = cin.
REQ-006 The combinational result SHALL equal {cout, sum} = a + b + cin computed at N+1 bits, with no truncation of the carry.
REQ-007 ovf SHALL equal c_N ^ c_(N-1), which is signed overflow when a and b are read as two's-complement numbers. For N=1, ovf SHALL equal c_1 ^ cin.
REQ-008 On a rising clk edge with in_valid=1, sum, cout and ovf SHALL load the combinational result, and out_valid SHALL be set to 1. Latency is exactly 1 cycle.
REQ-009 On a rising clk edge with in_valid=0, sum, cout and ovf SHALL hold their previous values, and out_valid SHALL be cleared to 0.
REQ-010 Back-to-back valid inputs SHALL be accepted every cycle with no stall. Throughput is one result per cycle, and there is no backpressure input.
REQ-011 Wrap-around: a carry out of bit N-1 SHALL appear only on cout; sum SHALL be the low N bits.
REQ-012 Inputs SHALL be sampled only at clock edges. Input changes between edges SHALL NOT affect the outputs.

Reset
REQ-013 When rst_n is asserted low, sum, cout, ovf and out_valid SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-014 While rst_n is low, all outputs SHALL stay 0 regardless of in_valid or clk.
REQ-015 When rst_n deasserts, the first clk edge with rst_n=1 and in_valid=1 SHALL load a result per REQ-008.
REQ-016 Reset asserted mid-stream SHALL discard any result being computed, with no partial update.

Verification
REQ-017 N=16 directed vectors, each applied with in_valid=1; the response is checked one cycle later with out_valid=1.
- a=1, b=2, cin=0 -> sum=3, cout=0, ovf=0.
- a=6, b=8, cin=1 -> sum=15, cout=0.
- a=11, b=13, cin=1 -> sum=25, cout=0.
REQ-018 Unsigned wrap at N=16:
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-019 Signed overflow at N=16:
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
REQ-020 Hold and valid behaviour:
- Present a valid vector, then drop in_valid and change a and b.
- Required: sum and cout are unchanged, and out_valid=0 on the following cycle.
REQ-021 Reset mid-operation: pull rst_n low between clock edges while outputs are nonzero -> all outputs read 0 before the next edge and stay 0 until a valid input arrives after deassertion.
REQ-022 Exhaustive check at N=4: all 512 combinations of a, b and cin match the reference a+b+cin for sum, cout and ovf. Repeat 10k random vectors at N=1 and N=32.
